// File: rtl/aes_stream_ctrl_if.sv
// Host-side stream interface of the AES control sequencer: key load, CTR counter load,
// block in/out handshakes and status.
interface aes_stream_ctrl_if #(
  parameter int CTR_W = 32
);
  logic             key_load_i;
  logic             key_load_ready_o;
  logic             key_ready_o;
  logic             mode_i;
  logic             ctr_load_i;
  logic [CTR_W-1:0] ctr_i;
  logic [CTR_W-1:0] ctr_blk_o;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             mode_o;
  logic             busy_o;

  modport master (
    output key_load_i, mode_i, ctr_load_i, ctr_i, in_valid_i, out_ready_i,
    input  key_load_ready_o, key_ready_o, ctr_blk_o, in_ready_o, out_valid_o, mode_o, busy_o
  );

  modport slave (
    input  key_load_i, mode_i, ctr_load_i, ctr_i, in_valid_i, out_ready_i,
    output key_load_ready_o, key_ready_o, ctr_blk_o, in_ready_o, out_valid_o, mode_o, busy_o
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// Control sequencer for an iterative AES datapath: up-front key expansion, streamed
// block rounds with back-to-back issue, and a CTR-mode block counter.
module aes_stream_ctrl #(
  parameter int KEY_BITS    = 128,
  parameter int PIPE_STAGES = 1,
  parameter int CTR_W       = 32
) (
  input  logic              clk,
  input  logic              nrst,
  aes_stream_ctrl_if.slave  host,
  output logic              gen_key_o,
  output logic              key_sub_o,
  output logic              next_rnd_o,
  output logic [7:0]        rcon_o,
  output logic              en_rnd_o,
  output logic              zero_rnd_o,
  output logic              final_rnd_o,
  output logic [3:0]        rnd_idx_o
);

  localparam int         NR        = 6 + KEY_BITS / 32;
  localparam int         STEP      = 1 + PIPE_STAGES;
  localparam logic [1:0] STEP_LAST = 2'(STEP - 1);
  localparam logic [3:0] NR_IDX    = 4'(NR);
  localparam logic [7:0] RCON_POLY = 8'h1b;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_stream_ctrl: KEY_BITS must be 128, 192 or 256");
    end
    if (PIPE_STAGES < 0 || PIPE_STAGES > 3) begin : g_bad_pipe_stages
      $error("aes_stream_ctrl: PIPE_STAGES must be in 0..3");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    KEY_GEN,
    KEY_EXP,
    LOAD,
    ROUND,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       rnd_idx_reg, rnd_idx_next;
  logic [1:0]       step_reg, step_next;
  logic [7:0]       rcon_reg, rcon_next;
  logic             key_ready_reg, key_ready_next;
  logic             mode_reg, mode_next;
  logic [CTR_W-1:0] ctr_reg, ctr_next;
  logic [CTR_W-1:0] ctr_blk_reg, ctr_blk_next;

  logic [7:0] rcon_xtime;
  logic       key_acc;
  logic       blk_acc;
  logic       in_ready;
  logic       step_last;
  logic       rnd_last;

  // GF(2^8) doubling of the round constant, reduced by x^8 + x^4 + x^3 + x + 1.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_xtime
      if (gi == 0) begin : g_lsb
        assign rcon_xtime[gi] = rcon_reg[7];
      end else begin : g_bit
        assign rcon_xtime[gi] = rcon_reg[gi-1] ^ (rcon_reg[7] & RCON_POLY[gi]);
      end
    end
  endgenerate

  assign step_last = (step_reg == STEP_LAST);
  assign rnd_last  = (rnd_idx_reg == NR_IDX);

  // A pending key or counter load in IDLE takes priority over a block.
  assign in_ready = key_ready_reg && !host.key_load_i && !host.ctr_load_i &&
                    (state_reg == IDLE || (state_reg == DONE && host.out_ready_i));
  assign key_acc  = host.key_load_i && (state_reg == IDLE);
  assign blk_acc  = host.in_valid_i && in_ready;

  assign host.key_load_ready_o = (state_reg == IDLE);
  assign host.key_ready_o      = key_ready_reg;
  assign host.in_ready_o       = in_ready;
  assign host.out_valid_o      = (state_reg == DONE);
  assign host.busy_o           = (state_reg != IDLE);
  assign host.mode_o           = mode_reg;
  assign host.ctr_blk_o        = ctr_blk_reg;
  assign rcon_o                = rcon_reg;
  assign rnd_idx_o             = rnd_idx_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      rnd_idx_reg   <= 4'd0;
      step_reg      <= 2'd0;
      rcon_reg      <= 8'h01;
      key_ready_reg <= 1'b0;
      mode_reg      <= 1'b0;
      ctr_reg       <= '0;
      ctr_blk_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      rnd_idx_reg   <= rnd_idx_next;
      step_reg      <= step_next;
      rcon_reg      <= rcon_next;
      key_ready_reg <= key_ready_next;
      mode_reg      <= mode_next;
      ctr_reg       <= ctr_next;
      ctr_blk_reg   <= ctr_blk_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rnd_idx_next   = rnd_idx_reg;
    step_next      = step_reg;
    rcon_next      = rcon_reg;
    key_ready_next = key_ready_reg;
    mode_next      = mode_reg;
    ctr_next       = ctr_reg;
    ctr_blk_next   = ctr_blk_reg;
    gen_key_o      = 1'b0;
    key_sub_o      = 1'b0;
    next_rnd_o     = 1'b0;
    en_rnd_o       = 1'b0;
    zero_rnd_o     = 1'b0;
    final_rnd_o    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (host.ctr_load_i) begin
          ctr_next = host.ctr_i;
        end
        if (key_acc) begin
          state_next     = KEY_GEN;
          key_ready_next = 1'b0;
          rcon_next      = 8'h01;
        end else if (blk_acc) begin
          state_next = LOAD;
        end
      end

      KEY_GEN: begin
        gen_key_o    = 1'b1;
        state_next   = KEY_EXP;
        rnd_idx_next = 4'd1;
        step_next    = 2'd0;
      end

      KEY_EXP: begin
        key_sub_o  = (step_reg == 2'd0);
        next_rnd_o = step_last;
        if (step_last) begin
          rcon_next = rcon_xtime;
          step_next = 2'd0;
          if (rnd_last) begin
            state_next     = IDLE;
            key_ready_next = 1'b1;
            rnd_idx_next   = 4'd0;
          end else begin
            rnd_idx_next = rnd_idx_reg + 4'd1;
          end
        end else begin
          step_next = step_reg + 2'd1;
        end
      end

      LOAD: begin
        en_rnd_o     = 1'b1;
        zero_rnd_o   = 1'b1;
        state_next   = ROUND;
        rnd_idx_next = 4'd1;
        step_next    = 2'd0;
      end

      ROUND: begin
        en_rnd_o    = step_last;
        final_rnd_o = rnd_last;
        if (step_last) begin
          step_next = 2'd0;
          if (rnd_last) begin
            state_next   = DONE;
            rnd_idx_next = 4'd0;
          end else begin
            rnd_idx_next = rnd_idx_reg + 4'd1;
          end
        end else begin
          step_next = step_reg + 2'd1;
        end
      end

      DONE: begin
        if (blk_acc) begin
          state_next = LOAD;
        end else if (host.out_ready_i) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Block accept from IDLE or DONE: latch mode and, in CTR mode, claim a counter value.
    if (blk_acc) begin
      mode_next    = host.mode_i;
      rnd_idx_next = 4'd0;
      step_next    = 2'd0;
      if (host.mode_i) begin
        ctr_blk_next = ctr_reg;
        ctr_next     = ctr_reg + CTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench: a 128-bit/PIPE1 instance and a 256-bit/PIPE0 instance, with
// a block scoreboard keyed on accept and checked on output handshake.
module tb_aes_stream_ctrl;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  aes_stream_ctrl_if #(.CTR_W(32)) ha ();
  aes_stream_ctrl_if #(.CTR_W(32)) hb ();

  logic       a_gen_key, a_key_sub, a_next_rnd, a_en_rnd, a_zero_rnd, a_final_rnd;
  logic [7:0] a_rcon;
  logic [3:0] a_rnd_idx;
  logic       b_gen_key, b_key_sub, b_next_rnd, b_en_rnd, b_zero_rnd, b_final_rnd;
  logic [7:0] b_rcon;
  logic [3:0] b_rnd_idx;

  aes_stream_ctrl #(.KEY_BITS(128), .PIPE_STAGES(1), .CTR_W(32)) dut_a (
    .clk(clk), .nrst(nrst), .host(ha),
    .gen_key_o(a_gen_key), .key_sub_o(a_key_sub), .next_rnd_o(a_next_rnd),
    .rcon_o(a_rcon), .en_rnd_o(a_en_rnd), .zero_rnd_o(a_zero_rnd),
    .final_rnd_o(a_final_rnd), .rnd_idx_o(a_rnd_idx)
  );

  aes_stream_ctrl #(.KEY_BITS(256), .PIPE_STAGES(0), .CTR_W(32)) dut_b (
    .clk(clk), .nrst(nrst), .host(hb),
    .gen_key_o(b_gen_key), .key_sub_o(b_key_sub), .next_rnd_o(b_next_rnd),
    .rcon_o(b_rcon), .en_rnd_o(b_en_rnd), .zero_rnd_o(b_zero_rnd),
    .final_rnd_o(b_final_rnd), .rnd_idx_o(b_rnd_idx)
  );

  typedef struct packed {
    logic        mode;
    logic [31:0] ctr;
  } exp_t;

  exp_t        sb_q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [31:0] a_model_ctr = 32'h0;
  logic [31:0] a_model_blk = 32'h0;
  logic [7:0]  rcon_tab [0:13] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                   8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    ha.key_load_i = 0; ha.mode_i = 0; ha.ctr_load_i = 0; ha.ctr_i = 0;
    ha.in_valid_i = 1; ha.out_ready_i = 0;
    hb.key_load_i = 0; hb.mode_i = 0; hb.ctr_load_i = 0; hb.ctr_i = 0;
    hb.in_valid_i = 0; hb.out_ready_i = 0;
    nrst = 0;
    step(); step();
    total_cnt++;
    if ({ha.busy_o, ha.key_ready_o, ha.in_ready_o, ha.out_valid_o, ha.mode_o} !== 5'b0)
      $display("FAIL reset_status: got %b want 00000",
               {ha.busy_o, ha.key_ready_o, ha.in_ready_o, ha.out_valid_o, ha.mode_o});
    else pass_cnt++;
    total_cnt++;
    if ({a_gen_key, a_key_sub, a_next_rnd, a_en_rnd, a_zero_rnd, a_final_rnd} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 000000",
               {a_gen_key, a_key_sub, a_next_rnd, a_en_rnd, a_zero_rnd, a_final_rnd});
    else pass_cnt++;
    total_cnt++;
    if ({a_rcon, b_rcon, a_rnd_idx} !== {8'h01, 8'h01, 4'h0})
      $display("FAIL reset_rcon_idx: got %h want 01010", {a_rcon, b_rcon, a_rnd_idx});
    else pass_cnt++;
    total_cnt++;
    if ({ha.ctr_blk_o, ha.key_load_ready_o} !== {32'h0, 1'b1})
      $display("FAIL reset_ctr_klr: got %h want %h", {ha.ctr_blk_o, ha.key_load_ready_o}, {32'h0, 1'b1});
    else pass_cnt++;
    ha.in_valid_i = 0;
    nrst = 1;
    step();
  endtask

  task automatic test_key_expansion_128();
    int pulses;
    int k;
    bit first;
    pulses = 0;
    ha.key_load_i = 1;
    #1;
    total_cnt++;
    if (ha.key_load_ready_o !== 1'b1)
      $display("FAIL key128_load_ready: got %b want 1", ha.key_load_ready_o);
    else pass_cnt++;
    step();
    ha.key_load_i = 0;
    total_cnt++;
    if ({a_gen_key, ha.key_ready_o, ha.busy_o, a_rcon} !== {3'b101, 8'h01})
      $display("FAIL key128_gen: got %h want %h", {a_gen_key, ha.key_ready_o, ha.busy_o, a_rcon}, {3'b101, 8'h01});
    else pass_cnt++;
    for (int c = 1; c <= 20; c++) begin
      step();
      k = (c - 1) / 2 + 1;
      first = ((c - 1) % 2 == 0);
      total_cnt++;
      if ({a_gen_key, a_key_sub, a_next_rnd, ha.key_ready_o} !== {1'b0, first, !first, 1'b0})
        $display("FAIL key128_strobe c=%0d: got %b want %b", c,
                 {a_gen_key, a_key_sub, a_next_rnd, ha.key_ready_o}, {1'b0, first, !first, 1'b0});
      else pass_cnt++;
      total_cnt++;
      if ({a_rnd_idx, a_rcon} !== {4'(k), rcon_tab[k-1]})
        $display("FAIL key128_idx_rcon c=%0d: got %h want %h", c, {a_rnd_idx, a_rcon}, {4'(k), rcon_tab[k-1]});
      else pass_cnt++;
      if (a_next_rnd) pulses++;
    end
    total_cnt++;
    if (pulses != 10) $display("FAIL key128_pulses: got %0d want 10", pulses);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({ha.key_ready_o, ha.busy_o} !== 2'b10)
      $display("FAIL key128_ready_e21: got %b want 10", {ha.key_ready_o, ha.busy_o});
    else pass_cnt++;
  endtask

  task automatic test_key_expansion_256();
    int cyc;
    hb.key_load_i = 1;
    step();
    hb.key_load_i = 0;
    total_cnt++;
    if (b_gen_key !== 1'b1) $display("FAIL key256_gen: got %b want 1", b_gen_key);
    else pass_cnt++;
    cyc = 0;
    while (cyc < 50) begin
      step();
      cyc++;
      if (hb.key_ready_o) break;
      total_cnt++;
      if ({b_key_sub, b_next_rnd, b_rnd_idx, b_rcon} !== {2'b11, 4'(cyc), rcon_tab[(cyc-1) % 14]})
        $display("FAIL key256_step c=%0d: got %h want %h", cyc,
                 {b_key_sub, b_next_rnd, b_rnd_idx, b_rcon}, {2'b11, 4'(cyc), rcon_tab[(cyc-1) % 14]});
      else pass_cnt++;
    end
    total_cnt++;
    if (cyc != 15 || hb.key_ready_o !== 1'b1)
      $display("FAIL key256_latency: got %0d cycles ready=%b want 15 ready=1", cyc, hb.key_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_ecb_256();
    exp_t e;
    hb.in_valid_i = 1;
    hb.mode_i = 0;
    #1;
    total_cnt++;
    if (hb.in_ready_o !== 1'b1) $display("FAIL ecb256_in_ready: got %b want 1", hb.in_ready_o);
    else pass_cnt++;
    sb_q.push_back('{mode: 1'b0, ctr: 32'h0});
    step();
    hb.in_valid_i = 0;
    total_cnt++;
    if ({b_en_rnd, b_zero_rnd, b_rnd_idx} !== {2'b11, 4'h0})
      $display("FAIL ecb256_load: got %b want 110000", {b_en_rnd, b_zero_rnd, b_rnd_idx});
    else pass_cnt++;
    for (int c = 1; c <= 14; c++) begin
      step();
      total_cnt++;
      if ({b_en_rnd, b_zero_rnd, b_final_rnd, hb.out_valid_o, b_rnd_idx} !==
          {1'b1, 1'b0, (c == 14), 1'b0, 4'(c)})
        $display("FAIL ecb256_round c=%0d: got %b want %b", c,
                 {b_en_rnd, b_zero_rnd, b_final_rnd, hb.out_valid_o, b_rnd_idx},
                 {1'b1, 1'b0, (c == 14), 1'b0, 4'(c)});
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({hb.out_valid_o, hb.busy_o} !== 2'b11)
      $display("FAIL ecb256_out_valid_e15: got %b want 11", {hb.out_valid_o, hb.busy_o});
    else pass_cnt++;
    hb.out_ready_i = 1;
    #1;
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL ecb256_sb: got empty queue want one entry");
    else begin
      e = sb_q.pop_front();
      if ({hb.mode_o, hb.ctr_blk_o} !== e) $display("FAIL ecb256_sb: got %h want %h", {hb.mode_o, hb.ctr_blk_o}, e);
      else pass_cnt++;
    end
    step();
    hb.out_ready_i = 0;
    total_cnt++;
    if ({hb.out_valid_o, hb.busy_o} !== 2'b00)
      $display("FAIL ecb256_drain: got %b want 00", {hb.out_valid_o, hb.busy_o});
    else pass_cnt++;
  endtask

  task automatic test_ctr_back_to_back();
    exp_t e;
    int acc, done, cyc;
    bit bb;
    acc = 0; done = 0; cyc = 0; bb = 0;
    ha.ctr_load_i = 1;
    ha.ctr_i = 32'hFFFF_FFFE;
    ha.in_valid_i = 1;
    ha.mode_i = 1;
    #1;
    total_cnt++;
    if (ha.in_ready_o !== 1'b0) $display("FAIL ctr_load_blocks: got %b want 0", ha.in_ready_o);
    else pass_cnt++;
    step();
    ha.ctr_load_i = 0;
    a_model_ctr = 32'hFFFF_FFFE;
    ha.out_ready_i = 1;
    while (done < 3 && cyc < 300) begin
      #1;
      if (ha.out_valid_o && ha.out_ready_i) begin
        total_cnt++;
        if (sb_q.size() == 0) $display("FAIL ctr_sb: got empty queue want entry");
        else begin
          e = sb_q.pop_front();
          if ({ha.mode_o, ha.ctr_blk_o} !== e)
            $display("FAIL ctr_sb blk=%0d: got %h want %h", done, {ha.mode_o, ha.ctr_blk_o}, e);
          else pass_cnt++;
        end
        done++;
        bb = ha.in_valid_i && ha.in_ready_o;
      end
      if (ha.in_valid_i && ha.in_ready_o) begin
        sb_q.push_back('{mode: 1'b1, ctr: a_model_ctr});
        a_model_blk = a_model_ctr;
        a_model_ctr = a_model_ctr + 32'd1;
        acc++;
      end
      step();
      if (bb) begin
        total_cnt++;
        if ({a_zero_rnd, a_en_rnd, ha.busy_o, ha.ctr_blk_o} !== {3'b111, a_model_blk})
          $display("FAIL ctr_no_bubble: got %h want %h", {a_zero_rnd, a_en_rnd, ha.busy_o, ha.ctr_blk_o},
                   {3'b111, a_model_blk});
        else pass_cnt++;
        bb = 0;
      end
      if (acc == 3) ha.in_valid_i = 0;
      cyc++;
    end
    total_cnt++;
    if (done != 3) $display("FAIL ctr_timeout: got %0d blocks want 3", done);
    else pass_cnt++;
    ha.out_ready_i = 0;
    ha.mode_i = 0;
    total_cnt++;
    if (ha.busy_o !== 1'b0) $display("FAIL ctr_idle_after: got busy=%b want 0", ha.busy_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int cyc;
    ha.in_valid_i = 1;
    ha.mode_i = 0;
    ha.out_ready_i = 0;
    #1;
    sb_q.push_back('{mode: 1'b0, ctr: a_model_blk});
    step();
    ha.in_valid_i = 0;
    cyc = 0;
    while (!ha.out_valid_o && cyc < 100) begin
      step();
      cyc++;
    end
    total_cnt++;
    if (cyc != 21) $display("FAIL bp_latency: got %0d cycles want 21", cyc);
    else pass_cnt++;
    ha.in_valid_i = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++;
      if ({ha.out_valid_o, ha.in_ready_o, a_en_rnd, a_zero_rnd, a_gen_key, a_next_rnd, a_key_sub} !== 7'b1000000)
        $display("FAIL bp_hold c=%0d: got %b want 1000000", c,
                 {ha.out_valid_o, ha.in_ready_o, a_en_rnd, a_zero_rnd, a_gen_key, a_next_rnd, a_key_sub});
      else pass_cnt++;
      step();
    end
    ha.in_valid_i = 0;
    ha.out_ready_i = 1;
    #1;
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL bp_sb: got empty queue want entry");
    else begin
      e = sb_q.pop_front();
      if ({ha.mode_o, ha.ctr_blk_o} !== e) $display("FAIL bp_sb: got %h want %h", {ha.mode_o, ha.ctr_blk_o}, e);
      else pass_cnt++;
    end
    step();
    ha.out_ready_i = 0;
    total_cnt++;
    if ({ha.out_valid_o, ha.busy_o} !== 2'b00)
      $display("FAIL bp_release: got %b want 00", {ha.out_valid_o, ha.busy_o});
    else pass_cnt++;
  endtask

  task automatic test_key_block_collision();
    exp_t e;
    int cyc;
    ha.key_load_i = 1;
    ha.in_valid_i = 1;
    ha.mode_i = 0;
    #1;
    total_cnt++;
    if ({ha.in_ready_o, ha.key_load_ready_o} !== 2'b01)
      $display("FAIL coll_ready: got %b want 01", {ha.in_ready_o, ha.key_load_ready_o});
    else pass_cnt++;
    step();
    ha.key_load_i = 0;
    ha.in_valid_i = 0;
    total_cnt++;
    if ({a_gen_key, ha.key_ready_o, a_zero_rnd} !== 3'b100)
      $display("FAIL coll_key_wins: got %b want 100", {a_gen_key, ha.key_ready_o, a_zero_rnd});
    else pass_cnt++;
    cyc = 0;
    while (!ha.key_ready_o && cyc < 50) begin
      step();
      cyc++;
    end
    total_cnt++;
    if (ha.key_ready_o !== 1'b1) $display("FAIL coll_key_timeout: got ready=%b want 1", ha.key_ready_o);
    else pass_cnt++;
    ha.in_valid_i = 1;
    #1;
    sb_q.push_back('{mode: 1'b0, ctr: a_model_blk});
    step();
    ha.in_valid_i = 0;
    step(); step(); step();
    ha.key_load_i = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++;
      if (ha.key_load_ready_o !== 1'b0) $display("FAIL coll_klr_round c=%0d: got %b want 0", c, ha.key_load_ready_o);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({a_gen_key, ha.key_ready_o, ha.busy_o} !== 3'b011)
        $display("FAIL coll_key_ignored c=%0d: got %b want 011", c, {a_gen_key, ha.key_ready_o, ha.busy_o});
      else pass_cnt++;
    end
    ha.key_load_i = 0;
    ha.out_ready_i = 1;
    cyc = 0;
    while (!ha.out_valid_o && cyc < 100) begin
      step();
      cyc++;
    end
    total_cnt++;
    if (sb_q.size() == 0 || !ha.out_valid_o) $display("FAIL coll_sb: got valid=%b want 1 with entry", ha.out_valid_o);
    else begin
      e = sb_q.pop_front();
      if ({ha.mode_o, ha.ctr_blk_o} !== e) $display("FAIL coll_sb: got %h want %h", {ha.mode_o, ha.ctr_blk_o}, e);
      else pass_cnt++;
    end
    step();
    ha.out_ready_i = 0;
  endtask

  task automatic test_reset_mid_round();
    int cyc;
    ha.ctr_load_i = 1;
    ha.ctr_i = 32'h0000_0055;
    step();
    ha.ctr_load_i = 0;
    ha.in_valid_i = 1;
    ha.mode_i = 1;
    step();
    ha.in_valid_i = 0;
    ha.mode_i = 0;
    step(); step(); step(); step();
    total_cnt++;
    if ({ha.busy_o, ha.mode_o, ha.ctr_blk_o} !== {2'b11, 32'h55})
      $display("FAIL rst_pre: got %h want %h", {ha.busy_o, ha.mode_o, ha.ctr_blk_o}, {2'b11, 32'h55});
    else pass_cnt++;
    ha.in_valid_i = 1;
    #1;
    nrst = 0;
    #1;
    total_cnt++;
    if ({ha.busy_o, ha.key_ready_o, ha.out_valid_o, ha.mode_o, ha.in_ready_o,
         a_en_rnd, a_final_rnd, a_zero_rnd, a_gen_key} !== 9'b0)
      $display("FAIL rst_async_status: got %b want 000000000",
               {ha.busy_o, ha.key_ready_o, ha.out_valid_o, ha.mode_o, ha.in_ready_o,
                a_en_rnd, a_final_rnd, a_zero_rnd, a_gen_key});
    else pass_cnt++;
    total_cnt++;
    if ({ha.ctr_blk_o, a_rcon, a_rnd_idx, ha.key_load_ready_o} !== {32'h0, 8'h01, 4'h0, 1'b1})
      $display("FAIL rst_async_regs: got %h want %h", {ha.ctr_blk_o, a_rcon, a_rnd_idx, ha.key_load_ready_o},
               {32'h0, 8'h01, 4'h0, 1'b1});
    else pass_cnt++;
    sb_q.delete();
    a_model_ctr = 32'h0;
    step();
    nrst = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (ha.in_ready_o !== 1'b0) $display("FAIL rst_no_key c=%0d: got in_ready=%b want 0", c, ha.in_ready_o);
      else pass_cnt++;
      step();
    end
    ha.in_valid_i = 0;
    ha.key_load_i = 1;
    step();
    ha.key_load_i = 0;
    cyc = 0;
    while (!ha.key_ready_o && cyc < 50) begin
      step();
      cyc++;
    end
    ha.in_valid_i = 1;
    ha.mode_i = 1;
    #1;
    total_cnt++;
    if (ha.in_ready_o !== 1'b1) $display("FAIL rst_rekey_ready: got %b want 1", ha.in_ready_o);
    else pass_cnt++;
    step();
    ha.in_valid_i = 0;
    ha.mode_i = 0;
    total_cnt++;
    if ({ha.mode_o, ha.ctr_blk_o} !== {1'b1, a_model_ctr})
      $display("FAIL rst_ctr_cleared: got %h want %h", {ha.mode_o, ha.ctr_blk_o}, {1'b1, a_model_ctr});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_key_expansion_128();
    test_key_expansion_256();
    test_ecb_256();
    test_ctr_back_to_back();
    test_backpressure();
    test_key_block_collision();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
